// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: shares one APB master port between two local requesters.
// A round-robin grant selects a requester. The block latches its descriptor
// and runs the SETUP/ACCESS sequence, which may include wait states. It then
// returns read data, the error flag and a one-cycle done pulse to that requester.
// Optional build macro APB_TIMEOUT_EN aborts an ACCESS phase after TO_CYCLES
// wait states and reports it as an error completion.
// Every output is a register. The bus registers also hold the latched descriptor.
module apb_rr_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
`ifdef APB_TIMEOUT_EN
  , parameter int TO_CYCLES = 16
`endif
) (
  input  logic          Pclk,
  input  logic          Presetn,
  // requester 0
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  // requester 1
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  // APB master port
  output logic          Psel,
  output logic          Penable,
  output logic [AW-1:0] Paddr,
  output logic          Pwrite,
  output logic [DW-1:0] PWdata,
  input  logic [DW-1:0] PRdata,
  input  logic          Pready,
  input  logic          Pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_n;
  logic          owner, owner_n;      // requester that owns the current transfer
  logic          last, last_n;        // requester served by the most recent grant
  logic          psel_n, penable_n, pwrite_n;
  logic [AW-1:0] paddr_n;
  logic [DW-1:0] pwdata_n;
  logic          done0_n, done1_n, err0_n, err1_n;
  logic [DW-1:0] rdata0_n, rdata1_n;

  logic          timeout;
  logic          complete;
  logic          elig0, elig1, win;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Count ACCESS cycles spent with Pready low; restart on every SETUP.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn)
      wait_cnt <= '0;
    else if (state == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !Pready)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Abort on the edge that ends the TO_CYCLES-th wait state.
  assign timeout = (state == ACCESS) && !Pready && (wait_cnt == CW'(TO_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign complete = (state == ACCESS) && (Pready || timeout);

  // A requester sits out the edge that completes its own transfer and the
  // following done cycle, so a request held through done counts as a new one.
  assign elig0 = req0 && !done0 && !(complete && owner == 1'b0);
  assign elig1 = req1 && !done1 && !(complete && owner == 1'b1);

  // On a tie, grant the requester that was not served last.
  assign win = (elig0 && elig1) ? ~last : elig1;

  // Next-state, bus and requester-side values; grants happen from IDLE or on completion.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_n   = state;
    owner_n   = owner;
    last_n    = last;
    psel_n    = Psel;
    penable_n = Penable;
    paddr_n   = Paddr;
    pwrite_n  = Pwrite;
    pwdata_n  = PWdata;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
    rdata0_n  = rdata0;
    rdata1_n  = rdata1;
    err0_n    = err0;
    err1_n    = err1;

    case (state)
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: begin
        if (complete) begin
          if (owner == 1'b0) begin
            done0_n  = 1'b1;
            rdata0_n = (Pready && !Pwrite) ? PRdata : '0;
            err0_n   = Pready ? Pslverr : 1'b1;
          end else begin
            done1_n  = 1'b1;
            rdata1_n = (Pready && !Pwrite) ? PRdata : '0;
            err1_n   = Pready ? Pslverr : 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (state == IDLE || complete) begin
      if (elig0 || elig1) begin
        state_n   = SETUP;
        owner_n   = win;
        last_n    = win;
        psel_n    = 1'b1;
        penable_n = 1'b0;
        paddr_n   = win ? addr1 : addr0;
        pwrite_n  = win ? wr1 : wr0;
        if (win)
          pwdata_n = wr1 ? wdata1 : '0;
        else
          pwdata_n = wr0 ? wdata0 : '0;
      end else begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
        paddr_n   = '0;
        pwrite_n  = 1'b0;
        pwdata_n  = '0;
      end
    end
  end

  // Register state, pointer and all outputs; reset forces the bus idle at once.
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      Psel    <= 1'b0;
      Penable <= 1'b0;
      Paddr   <= '0;
      Pwrite  <= 1'b0;
      PWdata  <= '0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_n;
      owner   <= owner_n;
      last    <= last_n;
      Psel    <= psel_n;
      Penable <= penable_n;
      Paddr   <= paddr_n;
      Pwrite  <= pwrite_n;
      PWdata  <= pwdata_n;
      done0   <= done0_n;
      done1   <= done1_n;
      rdata0  <= rdata0_n;
      rdata1  <= rdata1_n;
      err0    <= err0_n;
      err1    <= err1_n;
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios followed by random traffic.
// All outputs are compared each cycle against a transaction-level model.
// That model tracks the transfer in flight by its age in cycles.
// Define APB_TIMEOUT_EN for both files to include the timeout scenario.
module tb_apb_rr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          Pclk = 1'b0;
  logic          Presetn = 1'b0;
  logic          req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          Psel, Penable, Pwrite;
  logic [AW-1:0] Paddr;
  logic [DW-1:0] PWdata;
  logic [DW-1:0] PRdata = '0;
  logic          Pready = 1'b0, Pslverr = 1'b0;

  apb_rr_arbiter #(.AW(AW), .DW(DW)) dut (
    .Pclk(Pclk), .Presetn(Presetn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .Psel(Psel), .Penable(Penable), .Paddr(Paddr), .Pwrite(Pwrite),
    .PWdata(PWdata), .PRdata(PRdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the transfer in flight, its age (0 = setup cycle) and
  // the number of wait states seen so far, plus per-requester results.
  bit            m_busy;
  int            m_owner, m_age, m_waits, m_last;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wdata;
  bit   [1:0]    m_done;
  logic [DW-1:0] m_rdata [2];
  logic [1:0]    m_err;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_waits = 0; m_last = 1;
    m_addr = '0; m_wr = 0; m_wdata = '0; m_done = '0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_err = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic fin, abort;
    logic [1:0] elig;
    int pick;
    if (!Presetn) begin
      model_reset();
      return;
    end
    abort = 1'b0;
`ifdef APB_TIMEOUT_EN
    abort = m_busy && m_age >= 1 && !Pready && m_waits == TO - 1;
`endif
    fin = m_busy && m_age >= 1 && (Pready || abort);
    elig[0] = req0 && !m_done[0] && !(fin && m_owner == 0);
    elig[1] = req1 && !m_done[1] && !(fin && m_owner == 1);
    m_done = '0;
    if (fin) begin
      m_done[m_owner]  = 1'b1;
      m_rdata[m_owner] = (Pready && !m_wr) ? PRdata : '0;
      m_err[m_owner]   = abort ? 1'b1 : Pslverr;
    end
    if (m_busy && !fin) begin
      if (m_age >= 1 && !Pready) m_waits++;
      m_age++;
    end else if (elig != 2'b00) begin
      pick    = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
      m_owner = pick;
      m_last  = pick;
      m_busy  = 1;
      m_age   = 0;
      m_waits = 0;
      m_addr  = pick ? addr1 : addr0;
      m_wr    = pick ? wr1 : wr0;
      m_wdata = pick ? wdata1 : wdata0;
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic check_bus();
    check("psel",    Psel,    m_busy);
    check("penable", Penable, m_busy && m_age >= 1);
    check("paddr",   Paddr,   m_busy ? m_addr : '0);
    check("pwrite",  Pwrite,  m_busy ? m_wr : 1'b0);
    check("pwdata",  PWdata,  (m_busy && m_wr) ? m_wdata : '0);
    check("done0",   done0,   m_done[0]);
    check("done1",   done1,   m_done[1]);
    check("rdata0",  rdata0,  m_rdata[0]);
    check("rdata1",  rdata1,  m_rdata[1]);
    check("err0",    err0,    m_err[0]);
    check("err1",    err1,    m_err[1]);
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge Pclk);
    model_step();
    @(negedge Pclk);
    check_bus();
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; Pready = 0; Pslverr = 0;
    Presetn = 0;
    model_reset();
    cycle();
    cycle();
    Presetn = 1;
  endtask

  task automatic rand_drive();
    if (req0 && done0) req0 = ($urandom_range(3) == 0);
    else if (!req0)    req0 = ($urandom_range(2) == 0);
    if (req1 && done1) req1 = ($urandom_range(3) == 0);
    else if (!req1)    req1 = ($urandom_range(2) == 0);
    wr0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
    wr1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
    Pready  = ($urandom_range(2) != 0);
    PRdata  = DW'($urandom);
    Pslverr = ($urandom_range(3) == 0);
  endtask

  initial begin
    int pen, pcnt;
    bit found;
    int order[$];

    // Reset state
    model_reset();
    @(negedge Pclk);
    do_reset();
    check("rst_psel", Psel, 0);
    check("rst_done0", done0, 0);

    // Single write, zero wait states
    req0 = 1; wr0 = 1; addr0 = 4'h3; wdata0 = 8'hA5; Pready = 1;
    cycle();
    check("sw_setup_psel", Psel, 1);
    check("sw_setup_pen", Penable, 0);
    cycle();
    check("sw_access_pen", Penable, 1);
    check("sw_paddr", Paddr, 4'h3);
    check("sw_pwdata", PWdata, 8'hA5);
    cycle();
    check("sw_done0", done0, 1);
    check("sw_err0", err0, 0);
    check("sw_done1", done1, 0);
    req0 = 0;
    cycle();
    check("sw_done0_low", done0, 0);

    // Read with three wait states
    req1 = 1; wr1 = 0; addr1 = 4'h9; Pready = 0;
    cycle();
    pen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      pen += int'(Penable);
      check("rd_paddr_stable", Paddr, 4'h9);
      Pready = (i == 3);
      PRdata = (i == 3) ? 8'h3C : 8'h00;
    end
    cycle();
    check("rd_pen_cycles", pen, 4);
    check("rd_done1", done1, 1);
    check("rd_rdata1", rdata1, 8'h3C);
    req1 = 0;
    cycle();

    // Contention from reset: alternating grants, bus never idles
    do_reset();
    req0 = 1; wr0 = 1; addr0 = 4'h1; wdata0 = 8'h10;
    req1 = 1; wr1 = 1; addr1 = 4'h2; wdata1 = 8'h20; Pready = 1;
    pcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pcnt += int'(Psel);
      if (done0) order.push_back(0);
      if (done1) order.push_back(1);
    end
    check("cont_psel_cont", pcnt, 12);
    check("cont_ndone", order.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      check("cont_order", (order.size() > i) ? order[i] : 2, i % 2);
    req0 = 0; req1 = 0;
    cycle(); cycle(); cycle();

    // Slave error, then an error-free transfer clears it
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 4'h5; Pready = 1; Pslverr = 1; PRdata = 8'h5A;
    cycle(); cycle(); cycle();
    check("se_done0", done0, 1);
    check("se_err0", err0, 1);
    check("se_rdata0", rdata0, 8'h5A);
    wr0 = 1; wdata0 = 8'h77; Pslverr = 0;
    cycle(); cycle(); cycle(); cycle();
    check("se_done0_2", done0, 1);
    check("se_err0_clr", err0, 0);
    req0 = 0;
    cycle();

    // Reset in the middle of ACCESS
    req0 = 1; wr0 = 1; addr0 = 4'hC; wdata0 = 8'hEE; Pready = 0;
    cycle(); cycle();
    check("rm_in_access", Penable, 1);
    #2 Presetn = 0;
    #1;
    check("rm_psel", Psel, 0);
    check("rm_penable", Penable, 0);
    check("rm_paddr", Paddr, 0);
    check("rm_pwdata", PWdata, 0);
    check("rm_dones", {done0, done1}, 2'b00);
    model_reset();
    req1 = 1; wr1 = 0; addr1 = 4'hD;
    cycle();
    Presetn = 1;
    cycle();
    check("rm_tie_grant0", Paddr, 4'hC);
    Pready = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (done0) req0 = 0;
      if (done1) req1 = 0;
    end

`ifdef APB_TIMEOUT_EN
    // Timeout with requester 1 waiting
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 4'h2;
    req1 = 1; wr1 = 1; addr1 = 4'h7; wdata1 = 8'h11; Pready = 0;
    cycle();
    pen = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (done0) found = 1;
      else pen += int'(Penable);
    end
    check("to_done_seen", found, 1);
    check("to_waits", pen, TO);
    check("to_err0", err0, 1);
    check("to_rdata0", rdata0, 8'h00);
    check("to_next_setup", {Psel, Penable}, 2'b10);
    check("to_next_addr", Paddr, 4'h7);
    req0 = 0; Pready = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (done1) req1 = 0;
    end
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one APB master port between two local requesters (e.g. a CPU-side port and a DMA/config engine).
- Each requester presents a transfer descriptor (addr, wdata, wr) with a level request. The block grants, latches the descriptor, runs the APB SETUP/ACCESS sequence with wait states, and returns read data and a per-requester done pulse.
- Sits between the requesters and the APB slave(s).

Parameters:
- AW, 4, address width.
- DW, 8, data width.
- TO_CYCLES, 16, ACCESS wait-state limit; used only with APB_TIMEOUT_EN.

Ports:
- Pclk  in  1  APB clock.
- Presetn  in  1  reset.
- req0  in  1  requester 0 transfer request (level).
- wr0  in  1  requester 0: 1=write, 0=read.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- done0  out  1  requester 0 completion pulse.
- rdata0  out  DW  requester 0 read data, valid with done0.
- err0  out  1  requester 0 error, valid with done0.
- req1/wr1/addr1/wdata1/done1/rdata1/err1: same as above, for requester 1.
- Psel  out  1  APB select.
- Penable  out  1  APB enable.
- Paddr  out  AW  APB address.
- Pwrite  out  1  APB direction.
- PWdata  out  DW  APB write data.
- PRdata  in  DW  APB read data.
- Pready  in  1  APB ready.
- Pslverr  in  1  APB slave error.

Behaviour:
- Reset Presetn, asynchronous, active-low; clock Pclk.
- Reset values: all outputs 0; state=IDLE; last-served pointer=1, so requester 0 wins the first tie.
- All outputs are registered.

State machine (IDLE, SETUP, ACCESS):
- IDLE: if any eligible req is high, grant, latch that requester's wr/addr/wdata, go to SETUP. Otherwise stay in IDLE with Psel=0, Penable=0, Paddr=0, PWdata=0, Pwrite=0.
- SETUP: Psel=1, Penable=0, Paddr/Pwrite from the latched descriptor. PWdata = latched wdata if write, else 0. Next state is always ACCESS.
- ACCESS: Psel=1, Penable=1, bus signals held stable. Pready=0 -> stay in ACCESS (wait state). Pready=1 -> complete the transfer:
  - Drive done<g>=1 for exactly one cycle.
  - Load rdata<g> = PRdata for a read, or 0 for a write. Load err<g> = Pslverr.
  - If another eligible request is pending, arbitrate and go directly to SETUP (back-to-back, no IDLE cycle, Psel stays 1). Otherwise go to IDLE.

Arbitration:
- Only one requester high -> it wins.
- Both high -> the one not last served wins.
- The pointer updates on every grant.

Eligibility and requester handshake:
- A requester is ineligible on the completion edge of its own transfer and during the cycle its done is high. It must drop req (or present a new descriptor) in the done cycle.
- req held high after the done cycle is treated as a new request.
- Descriptor inputs matter only at the grant edge.
- Deasserting req mid-transfer does not abort; the transfer completes and done still pulses.

Latency:
- req0 rises before edge k in IDLE -> Psel=1 after k, Penable=1 after k+1.
- With Pready=1 at edge k+2: done0=1 in the cycle after k+2, i.e. 3 cycles from request to done with zero wait states.

Output holding:
- done<n> is 0 outside its pulse.
- rdata<n>/err<n> hold their last values until the next completion for that requester.

Other cases:
- Reset mid-transfer: bus returns to idle immediately; no done pulse is issued; the pointer resets.
- Pslverr is sampled only when Pready=1 in ACCESS.

Optional Feature:
APB_TIMEOUT_EN
- Defined: a wait counter clears in SETUP and increments each ACCESS cycle with Pready=0.
  - When the count reaches TO_CYCLES with Pready still 0, the transfer is aborted: done<g>=1, err<g>=1, rdata<g>=0, and Psel/Penable drop; the arbiter then proceeds as on a normal completion.
  - Counter width is clog2(TO_CYCLES+1).
- Undefined: no counter exists, and ACCESS waits for Pready indefinitely.

Test Plan:
- Single write: req0=1, wr0=1, addr0=4'h3, wdata0=8'hA5, Pready=1 -> Psel 1 then Penable 1 with Paddr=3, PWdata=A5, Pwrite=1; done0 pulses one cycle, err0=0, done1 never asserts.
- Read with wait states: req1=1, wr1=0, addr1=4'h9, Pready low for 3 ACCESS cycles, then PRdata=8'h3C with Pready=1 -> Penable high for 4 cycles; rdata1=3C with done1; Paddr stable throughout.
- Contention: req0 and req1 held high from reset, both writes, Pready=1 -> grant order 0,1,0,1; transfers back-to-back with Psel continuously 1; each done pulses once per transfer.
- Slave error: read with Pslverr=1, Pready=1 on completion -> err0=1, rdata0=PRdata; next error-free transfer clears err0 to 0.
- Reset mid-ACCESS: assert Presetn=0 while Penable=1 -> Psel, Penable, Paddr, PWdata and all done outputs go to 0 asynchronously; after release, a tie grants requester 0.
- APB_TIMEOUT_EN defined, TO_CYCLES=16, Pready held 0 -> done0 and err0 assert at wait-cycle 16 with rdata0=00; the pending req1 is granted in the next SETUP.
